// File: rtl/sram_frame_arbiter_if.sv
// Bundle of requester and SRAM-side signals around the frame-store arbiter.
// slave is the arbiter's view, master is the requester/pin side.
interface sram_frame_arbiter_if;
    logic        even_frame;
    logic        vga_req;
    logic [18:0] vga_addr;
    logic        vga_gnt;
    logic [15:0] vga_rdata;
    logic        vga_rvalid;
    logic        nfc_req;
    logic        nfc_we;
    logic        nfc_front;
    logic [18:0] nfc_addr;
    logic [15:0] nfc_wdata;
    logic        nfc_gnt;
    logic [15:0] nfc_rdata;
    logic        nfc_rvalid;
    logic [19:0] SRAM_ADDRESS;
    logic        SRAM_OE_N;
    logic        SRAM_WE_N;
    logic [15:0] Data_to_SRAM;
    logic        sram_drive;
    logic [15:0] Data_from_SRAM;
    logic        busy;

    modport slave (
        input  even_frame, vga_req, vga_addr, nfc_req, nfc_we, nfc_front,
               nfc_addr, nfc_wdata, Data_from_SRAM,
        output vga_gnt, vga_rdata, vga_rvalid, nfc_gnt, nfc_rdata, nfc_rvalid,
               SRAM_ADDRESS, SRAM_OE_N, SRAM_WE_N, Data_to_SRAM, sram_drive, busy
    );

    modport master (
        output even_frame, vga_req, vga_addr, nfc_req, nfc_we, nfc_front,
               nfc_addr, nfc_wdata, Data_from_SRAM,
        input  vga_gnt, vga_rdata, vga_rvalid, nfc_gnt, nfc_rdata, nfc_rvalid,
               SRAM_ADDRESS, SRAM_OE_N, SRAM_WE_N, Data_to_SRAM, sram_drive, busy
    );
endinterface

// File: rtl/sram_frame_arbiter.sv
// Shares one 16-bit SRAM between VGA scan-out reads and next-frame controller
// accesses on a double-buffered frame store, with bus-turnaround insertion.
//
//   state  | meaning
//   IDLE   | no access in flight, strobes high, bus released
//   ACCESS | OE_N or WE_N low for ACCESS_CYCLES cycles, address stable
//   TURN   | one dead cycle between read and write, winner already latched
module sram_frame_arbiter #(
    parameter int ACCESS_CYCLES  = 2,
    parameter int MAX_VGA_STREAK = 4
) (
    input logic             Clk,
    input logic             Reset_N,
    sram_frame_arbiter_if.slave bus
);
    localparam int SW = ($clog2(MAX_VGA_STREAK + 1) < 3) ? 3 : $clog2(MAX_VGA_STREAK + 1);
    localparam int CW = 3;

    typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] streak;
    logic          act_nfc, act_we;
    logic          pend_nfc, pend_we;
    logic [19:0]   pend_addr;
    logic [15:0]   pend_wdata;

    logic          vga_gnt, nfc_gnt, vga_rvalid, nfc_rvalid;
    logic [15:0]   vga_rdata, nfc_rdata, data_to_sram;
    logic [19:0]   sram_address;
    logic          oe_n, we_n, drive, busy;

    logic          any_req, last_cycle, decide, start;
    logic          win_nfc, win_we, win_bank;
    logic [19:0]   win_addr;
    logic          ld_nfc, ld_we;
    logic [19:0]   ld_addr;
    logic [15:0]   ld_wdata;

    always_comb begin
        any_req    = bus.vga_req | bus.nfc_req;
        last_cycle = (state == ACCESS) && (cnt == '0);
        decide     = any_req && ((state == IDLE) || last_cycle);
        win_nfc    = bus.nfc_req && (!bus.vga_req || (streak == SW'(MAX_VGA_STREAK)));
        win_we     = win_nfc & bus.nfc_we;
        win_bank   = (win_nfc && !bus.nfc_front) ? bus.even_frame : ~bus.even_frame;
        win_addr   = {win_bank, win_nfc ? bus.nfc_addr : bus.vga_addr};
        // A direction change at the end of an access detours through TURN.
        start      = (state == TURN) || (decide && !(last_cycle && (win_we != act_we)));
        ld_nfc     = (state == TURN) ? pend_nfc   : win_nfc;
        ld_we      = (state == TURN) ? pend_we    : win_we;
        ld_addr    = (state == TURN) ? pend_addr  : win_addr;
        ld_wdata   = (state == TURN) ? pend_wdata : bus.nfc_wdata;
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state        <= IDLE;
            cnt          <= '0;
            streak       <= '0;
            act_nfc      <= 1'b0;
            act_we       <= 1'b0;
            pend_nfc     <= 1'b0;
            pend_we      <= 1'b0;
            pend_addr    <= '0;
            pend_wdata   <= '0;
            vga_gnt      <= 1'b0;
            nfc_gnt      <= 1'b0;
            vga_rvalid   <= 1'b0;
            nfc_rvalid   <= 1'b0;
            vga_rdata    <= '0;
            nfc_rdata    <= '0;
            sram_address <= '0;
            data_to_sram <= '0;
            oe_n         <= 1'b1;
            we_n         <= 1'b1;
            drive        <= 1'b0;
            busy         <= 1'b0;
        end else begin
            vga_gnt    <= 1'b0;
            nfc_gnt    <= 1'b0;
            vga_rvalid <= 1'b0;
            nfc_rvalid <= 1'b0;

            if (!bus.nfc_req)
                streak <= '0;
            else if (decide)
                streak <= win_nfc ? '0 : ((streak == '1) ? streak : streak + 1'b1);

            if (decide) begin
                vga_gnt    <= ~win_nfc;
                nfc_gnt    <= win_nfc;
                pend_nfc   <= win_nfc;
                pend_we    <= win_we;
                pend_addr  <= win_addr;
                pend_wdata <= bus.nfc_wdata;
            end

            if (last_cycle && !act_we) begin
                if (act_nfc) begin
                    nfc_rdata  <= bus.Data_from_SRAM;
                    nfc_rvalid <= 1'b1;
                end else begin
                    vga_rdata  <= bus.Data_from_SRAM;
                    vga_rvalid <= 1'b1;
                end
            end

            if (start) begin
                state        <= ACCESS;
                busy         <= 1'b1;
                cnt          <= CW'(ACCESS_CYCLES - 1);
                sram_address <= ld_addr;
                oe_n         <= ld_we;
                we_n         <= ~ld_we;
                drive        <= ld_we;
                act_nfc      <= ld_nfc;
                act_we       <= ld_we;
                if (ld_we)
                    data_to_sram <= ld_wdata;
            end else if (state == ACCESS) begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    oe_n  <= 1'b1;
                    we_n  <= 1'b1;
                    drive <= 1'b0;
                    if (decide) begin
                        state <= TURN;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.vga_gnt      = vga_gnt;
    assign bus.nfc_gnt      = nfc_gnt;
    assign bus.vga_rvalid   = vga_rvalid;
    assign bus.nfc_rvalid   = nfc_rvalid;
    assign bus.vga_rdata    = vga_rdata;
    assign bus.nfc_rdata    = nfc_rdata;
    assign bus.SRAM_ADDRESS = sram_address;
    assign bus.Data_to_SRAM = data_to_sram;
    assign bus.SRAM_OE_N    = oe_n;
    assign bus.SRAM_WE_N    = we_n;
    assign bus.sram_drive   = drive;
    assign bus.busy         = busy;
endmodule
